// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: arbitrary depth, programmable almost thresholds,
// registered or first-word-fall-through read, synchronous flush, write-while-full on pop.
module sync_fifo_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               wr_en,
  input  logic [FIFO_WIDTH-1:0]              data_in,
  input  logic                               rd_en,
  output logic [FIFO_WIDTH-1:0]              data_out,
  output logic                               valid,
  output logic                               wr_ack,
  output logic                               overflow,
  output logic                               underflow,
  output logic                               full,
  output logic                               empty,
  output logic                               almostfull,
  output logic                               almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

  generate
    if (FIFO_WIDTH < 1 || FIFO_DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH ||
        AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1 || (FWFT != 0 && FWFT != 1)) begin : g_bad_param
      $fatal(1, "sync_fifo_param: illegal parameter combination");
    end
  endgenerate

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_wr_ack, r_overflow, r_underflow;
  logic                  w_rd_acc, w_wr_acc;

  // A pop in the same cycle frees the slot a full-FIFO write needs.
  assign w_rd_acc = rd_en && (r_count != '0);
  assign w_wr_acc = wr_en && ((r_count < DEPTH_C) || w_rd_acc);

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_rd_acc) r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_wr_ack    <= w_wr_acc;
      r_overflow  <= wr_en && !w_wr_acc;
      r_underflow <= rd_en && !w_rd_acc;
    end
  end

  // Storage is deliberately not reset; flush and reset only move the pointers.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_wr_acc) r_mem[r_wr_ptr] <= data_in;
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [FIFO_WIDTH-1:0] r_data_out;
      logic                  r_valid;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data_out <= '0;
          r_valid    <= 1'b0;
        end else if (flush) begin
          r_valid    <= 1'b0;
        end else begin
          r_valid <= w_rd_acc;
          if (w_rd_acc) r_data_out <= r_mem[r_rd_ptr];
        end
      end
      assign data_out = r_data_out;
      assign valid    = r_valid;
    end else begin : g_fwft_read
      assign data_out = r_mem[r_rd_ptr];
      assign valid    = (r_count != '0);
    end
  endgenerate

  assign wr_ack      = r_wr_ack;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign count       = r_count;
  assign full        = (r_count == DEPTH_C);
  assign empty       = (r_count == '0);
  assign almostfull  = (r_count >= AF_C);
  assign almostempty = (r_count <= AE_C);
endmodule
